// File: rtl/clock_set_ctrl.sv
// Mode/set controller for an hh:mm:ss counter chain: cascades carries in RUN,
// and in the SET modes steps hours or minutes from the increment button with auto-repeat.
module clock_set_ctrl #(
   parameter int HOLD_CYCLES   = 8,
   parameter int REPEAT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_inc,
   input  logic       i_sec_carry,
   input  logic       i_min_carry,
   output logic       o_sec_en,
   output logic       o_sec_clr,
   output logic       o_min_in,
   output logic       o_hr_in,
   output logic [1:0] o_mode,
   output logic       o_editing
);

   localparam logic [1:0] ST_RUN     = 2'b00;
   localparam logic [1:0] ST_SET_HR  = 2'b01;
   localparam logic [1:0] ST_SET_MIN = 2'b10;

   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic             r_btn_mode_q;
   logic             r_btn_inc_q;
   logic             r_sec_clr;
   logic             r_inc_p;
   logic             r_armed;
   logic             r_repeat;
   logic [CNT_W-1:0] r_cnt;

   logic             w_mode_press;
   logic             w_inc_edge;
   logic             w_in_set;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_mode_press = i_btn_mode & ~r_btn_mode_q;
   assign w_inc_edge   = i_btn_inc & ~r_btn_inc_q;
   assign w_in_set     = (r_state != ST_RUN);
   assign w_cnt_next   = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_next = r_state;
      if (w_mode_press) begin
         case (r_state)
            ST_RUN:    w_state_next = ST_SET_HR;
            ST_SET_HR: w_state_next = ST_SET_MIN;
            default:   w_state_next = ST_RUN;
         endcase
      end
   end

   // Button history resets high so a button held through reset release is not a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_btn_mode_q <= 1'b1;
         r_btn_inc_q  <= 1'b1;
         r_sec_clr    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_btn_mode_q <= i_btn_mode;
         r_btn_inc_q  <= i_btn_inc;
         r_sec_clr    <= (r_state == ST_SET_MIN) && w_mode_press;
      end
   end

   // A press arms the repeat engine; a mode press or button release disarms it,
   // so only a fresh low-to-high press in a SET mode can start pulsing again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inc_p  <= 1'b0;
         r_armed  <= 1'b0;
         r_repeat <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_inc_p <= 1'b0;
         if (w_mode_press || !i_btn_inc) begin
            r_armed  <= 1'b0;
            r_repeat <= 1'b0;
            r_cnt    <= '0;
         end else if (w_in_set && w_inc_edge) begin
            r_inc_p  <= 1'b1;
            r_armed  <= 1'b1;
            r_repeat <= 1'b0;
            r_cnt    <= '0;
         end else if (r_armed) begin
            if (!r_repeat && (w_cnt_next == CNT_W'(HOLD_CYCLES))) begin
               r_inc_p  <= 1'b1;
               r_repeat <= 1'b1;
               r_cnt    <= '0;
            end else if (r_repeat && (w_cnt_next == CNT_W'(REPEAT_CYCLES))) begin
               r_inc_p <= 1'b1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end
      end
   end

   // SET modes freeze the chain: ticks and carries are dropped, only inc_p reaches a field.
   always_comb begin
      o_sec_en = 1'b0;
      o_min_in = 1'b0;
      o_hr_in  = 1'b0;
      case (r_state)
         ST_RUN: begin
            o_sec_en = i_tick & ~r_sec_clr;
            o_min_in = i_sec_carry;
            o_hr_in  = i_min_carry;
         end
         ST_SET_HR:  o_hr_in  = r_inc_p;
         ST_SET_MIN: o_min_in = r_inc_p;
         default: begin
            o_sec_en = 1'b0;
            o_min_in = 1'b0;
            o_hr_in  = 1'b0;
         end
      endcase
   end

   assign o_sec_clr = r_sec_clr;
   assign o_mode    = r_state;
   assign o_editing = w_in_set;

endmodule
